pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_md_busy_counter.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register-index
// width, occupancy counter width and the controller state encoding.
package pipe_hazard_ctrl_pkg;

   // Width of an architectural register index.
   localparam int REG_IDX_W = 5;

   // Multiply/divide occupancy counter width (holds MD_LAT-1, MD_LAT <= 63).
   localparam int MD_CNT_W = 6;

   // Controller state encoding. ST_ILLEGAL is never entered on purpose; if it
   // is ever observed the controller falls back to ST_RUN on the next edge.
   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MD_BUSY   = 2'd1,
      ST_IMEM_WAIT = 2'd2,
      ST_ILLEGAL   = 2'd3
   } hz_state_t;

   // Load-use hazard: the load in E writes a real register (not r0) that the
   // instruction in D reads on either source port.
   function automatic logic is_load_use(
      input logic                 memread_e,
      input logic [REG_IDX_W-1:0] rt_e,
      input logic [REG_IDX_W-1:0] rs_d,
      input logic [REG_IDX_W-1:0] rt_d
   );
      return memread_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multiply/divide occupancy counter. Loaded when an MD operation starts,
// decremented on every busy cycle, and reports zero on the final busy cycle.
module md_busy_counter
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic [MD_CNT_W-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   logic [MD_CNT_W-1:0] count_q;

   // Load takes precedence; decrement stops at zero so the count never wraps.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller. Produces fetch/decode stall and flush controls
// for instruction-memory waits, multi-cycle multiply/divide occupancy,
// load-use hazards and taken branches. Controls are combinational from the
// registered state and the current inputs; state, MD counter, redirect flag
// and the stall statistics counter are registered.
//
// Handshake: imem_ready is a level qualifier, not a valid/ready pair. When it
// is low the fetch result is not usable this cycle, so PC is held and a
// bubble is inserted into IF/ID; the controller waits until it rises.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 imem_ready,
   input  logic                 memread_E,
   input  logic [REG_IDX_W-1:0] rt_E,
   input  logic [REG_IDX_W-1:0] rs_D,
   input  logic [REG_IDX_W-1:0] rt_D,
   input  logic                 branch_taken_D,
   input  logic                 md_start_D,
   output logic                 stall_F,
   output logic                 stall_D,
   output logic                 flush_D,
   output logic                 flush_E,
   output logic                 md_done,
   output logic [1:0]           state,
   output logic [15:0]          stall_cycles
);

   // Counter reload value: MD_LAT busy cycles follow the start cycle.
   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

   hz_state_t state_q;
   hz_state_t state_nxt;
   logic      redirect_q;
   logic      redirect_nxt;
   logic      md_load;
   logic      md_dec;
   logic      md_zero;
   logic      load_use;

   assign load_use = is_load_use(memread_E, rt_E, rs_D, rt_D);
   assign md_dec   = (state_q == ST_MD_BUSY);
   assign state    = state_q;

   md_busy_counter u_md_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (md_load),
      .load_val (MD_LOAD),
      .dec      (md_dec),
      .zero     (md_zero)
   );

   // Control outputs and next-state selection from state and current inputs.
   always_comb begin
      stall_F      = 1'b0;
      stall_D      = 1'b0;
      flush_D      = 1'b0;
      flush_E      = 1'b0;
      md_done      = 1'b0;
      md_load      = 1'b0;
      state_nxt    = state_q;
      redirect_nxt = redirect_q;
      case (state_q)
         ST_RUN: begin
            // A redirect latched during a fetch wait is consumed here.
            redirect_nxt = 1'b0;
            if (!imem_ready) begin
               stall_F   = 1'b1;
               flush_D   = 1'b1;
               state_nxt = ST_IMEM_WAIT;
            end else if (md_start_D) begin
               stall_F   = 1'b1;
               stall_D   = 1'b1;
               flush_E   = 1'b1;
               md_load   = 1'b1;
               state_nxt = ST_MD_BUSY;
            end else if (load_use) begin
               // Branch in D is not latched; D re-presents it next cycle.
               stall_F = 1'b1;
               stall_D = 1'b1;
               flush_E = 1'b1;
            end else if (branch_taken_D) begin
               flush_D = 1'b1;
            end
            if (redirect_q) begin
               flush_D = 1'b1;
            end
         end
         ST_MD_BUSY: begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            if (md_zero) begin
               md_done   = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_IMEM_WAIT: begin
            stall_F = 1'b1;
            flush_D = 1'b1;
            if (branch_taken_D) begin
               redirect_nxt = 1'b1;
            end
            if (imem_ready) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Controller state and pending-redirect flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         redirect_q <= redirect_nxt;
      end
   end

   // Saturating count of cycles in which fetch is held.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (stall_F && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule
